// File: rtl/arm_enc_pkg.sv
// Shared constants, state encoding and word builders for the ARM encoder.
// Opcode values match the decoder so both sides agree on field meaning.
package arm_enc_pkg;

    localparam logic [2:0] ENC_DP_RSI = 3'd0;
    localparam logic [2:0] ENC_DP_RSR = 3'd1;
    localparam logic [2:0] ENC_DP_IMM = 3'd2;
    localparam logic [2:0] ENC_MUL    = 3'd3;
    localparam logic [2:0] ENC_MLA    = 3'd4;
    localparam logic [2:0] ENC_UMULL  = 3'd5;
    localparam logic [2:0] ENC_SMULL  = 3'd6;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] MUL_MARK = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        s_bit;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [31:0] imm32;
    } imm_ctx_t;

    // Compare/test ops always set flags and have no destination;
    // moves have no first operand.
    function automatic logic [31:0] dp_word(
        input logic [3:0]  cond,
        input logic        imm,
        input logic [3:0]  opc,
        input logic        s,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [11:0] op2
    );
        logic       s_n;
        logic [3:0] rn_n;
        logic [3:0] rd_n;
        s_n  = s;
        rn_n = rn;
        rd_n = rd;
        if (opc[3:2] == 2'b10) begin
            s_n  = 1'b1;
            rd_n = 4'd0;
        end
        if (opc == OP_MOV || opc == OP_MVN)
            rn_n = 4'd0;
        return {cond, 2'b00, imm, opc, s_n, rn_n, rd_n, op2};
    endfunction

    function automatic logic [31:0] mul_word(
        input logic [3:0] cond,
        input logic       acc,
        input logic       s,
        input logic [3:0] rd,
        input logic [3:0] rn,
        input logic [3:0] rs,
        input logic [3:0] rm
    );
        logic [3:0] rn_n;
        rn_n = acc ? rn : 4'd0;
        return {cond, 6'b000000, acc, s, rd, rn_n, rs, MUL_MARK, rm};
    endfunction

    function automatic logic [31:0] long_word(
        input logic [3:0] cond,
        input logic       sgn,
        input logic       s,
        input logic [3:0] hi,
        input logic [3:0] lo,
        input logic [3:0] rs,
        input logic [3:0] rm
    );
        return {cond, 5'b00001, sgn, 1'b0, s, hi, lo, rs, MUL_MARK, rm};
    endfunction

endpackage

// File: rtl/arm_instr_encoder_rot_check.sv
// Tests whether imm32 is expressible as imm8 rotated right by 2*rot.
// Purely combinational so decoder benches can reuse it directly.
module arm_imm_rot_check (
    input  logic [31:0] imm32,
    input  logic [3:0]  rot,
    output logic        fit,
    output logic [7:0]  imm8
);

    logic [4:0]  sh;
    logic [31:0] v;

    always_comb begin
        sh   = {rot, 1'b0};
        v    = (imm32 << sh) | (imm32 >> (6'd32 - {1'b0, sh}));
        fit  = (v[31:8] == 24'd0);
        imm8 = v[7:0];
    end

endmodule

// File: rtl/arm_instr_encoder.sv
// ARM instruction encoder: field bundle in, 32-bit word out.
// Immediate operands are searched one rotate candidate per cycle.
module arm_instr_encoder
    import arm_enc_pkg::*;
#(
    parameter int MAX_ROT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  kind,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [1:0]  sh_type,
    input  logic [4:0]  sh_amt,
    input  logic [31:0] imm32,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err
);

    localparam logic [3:0] ROT_LAST = 4'(MAX_ROT);

    state_t      state;
    state_t      state_nx;
    imm_ctx_t    ctx;
    imm_ctx_t    ctx_in;
    logic [3:0]  rot;
    logic        fit;
    logic [7:0]  imm8;
    logic        legal;
    logic [31:0] direct_word;
    logic [31:0] imm_word;

    arm_imm_rot_check u_rot (
        .imm32 (ctx.imm32),
        .rot   (rot),
        .fit   (fit),
        .imm8  (imm8)
    );

    assign legal = (kind <= ENC_SMULL);

    always_comb begin
        ctx_in.cond   = cond;
        ctx_in.opcode = opcode;
        ctx_in.s_bit  = s_bit;
        ctx_in.rn     = rn;
        ctx_in.rd     = rd;
        ctx_in.imm32  = imm32;
    end

    always_comb begin
        direct_word = 32'd0;
        case (kind)
            ENC_DP_RSI:
                direct_word = dp_word(cond, 1'b0, opcode, s_bit, rn, rd,
                                      {sh_amt, sh_type, 1'b0, rm});
            ENC_DP_RSR:
                direct_word = dp_word(cond, 1'b0, opcode, s_bit, rn, rd,
                                      {rs, 1'b0, sh_type, 1'b1, rm});
            ENC_MUL:
                direct_word = mul_word(cond, 1'b0, s_bit, rd, rn, rs, rm);
            ENC_MLA:
                direct_word = mul_word(cond, 1'b1, s_bit, rd, rn, rs, rm);
            ENC_UMULL:
                direct_word = long_word(cond, 1'b0, s_bit, rd, rn, rs, rm);
            ENC_SMULL:
                direct_word = long_word(cond, 1'b1, s_bit, rd, rn, rs, rm);
            default:
                direct_word = 32'd0;
        endcase
    end

    assign imm_word = dp_word(ctx.cond, 1'b1, ctx.opcode, ctx.s_bit,
                              ctx.rn, ctx.rd, {rot, imm8});

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:
                if (in_valid)
                    state_nx = (kind == ENC_DP_IMM) ? ST_SEARCH : ST_OUT;
            ST_SEARCH:
                if (fit || rot == ROT_LAST)
                    state_nx = ST_OUT;
            ST_OUT:
                if (out_ready)
                    state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
    end

    // First fitting candidate wins, so the encoding is deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= 32'd0;
            err   <= 1'b0;
            rot   <= 4'd0;
            ctx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ctx   <= ctx_in;
                        rot   <= 4'd0;
                        err   <= ~legal;
                        instr <= (legal && kind != ENC_DP_IMM) ?
                                 direct_word : 32'd0;
                    end
                end
                ST_SEARCH: begin
                    if (fit) begin
                        instr <= imm_word;
                    end else if (rot == ROT_LAST) begin
                        instr <= 32'd0;
                        err   <= 1'b1;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Self-checking bench for arm_instr_encoder against a field-level model.
// Immediates are modelled by brute-force search over every imm8/rotate.
module tb_arm_instr_encoder;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        s_bit;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [1:0]  sh_type;
        logic [4:0]  sh_amt;
        logic [31:0] imm32;
    } fld_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  kind = '0;
    logic [3:0]  cond = '0;
    logic [3:0]  opcode = '0;
    logic        s_bit = 1'b0;
    logic [3:0]  rn = '0;
    logic [3:0]  rd = '0;
    logic [3:0]  rm = '0;
    logic [3:0]  rs = '0;
    logic [1:0]  sh_type = '0;
    logic [4:0]  sh_amt = '0;
    logic [31:0] imm32 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        err;

    int errors = 0;
    int checks = 0;

    arm_instr_encoder #(.MAX_ROT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .cond      (cond),
        .opcode    (opcode),
        .s_bit     (s_bit),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .rs        (rs),
        .sh_type   (sh_type),
        .sh_amt    (sh_amt),
        .imm32     (imm32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic fld_t mk(
        input int k, input int c, input int op, input int s,
        input int n, input int d, input int m, input int r,
        input int st, input int sa, input logic [31:0] im
    );
        fld_t f;
        f.kind = 3'(k);
        f.cond = 4'(c);
        f.opcode = 4'(op);
        f.s_bit = 1'(s);
        f.rn = 4'(n);
        f.rd = 4'(d);
        f.rm = 4'(m);
        f.rs = 4'(r);
        f.sh_type = 2'(st);
        f.sh_amt = 5'(sa);
        f.imm32 = im;
        return f;
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        if (n == 0)
            return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic int find_rot(input logic [31:0] v, output int i8);
        i8 = 0;
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 256; k++)
                if (ror32(32'(k), 2 * r) == v) begin
                    i8 = k;
                    return r;
                end
        return -1;
    endfunction

    task automatic ref_encode(input fld_t f, output logic [31:0] w,
                              output logic e, output int lat);
        int s, d, n, r, i8, op2, ibit;
        int c, op;
        c = int'(f.cond);
        op = int'(f.opcode);
        s = int'(f.s_bit);
        d = int'(f.rd);
        n = int'(f.rn);
        w = 0;
        e = 0;
        lat = 1;
        op2 = 0;
        ibit = 0;
        if (op >= 8 && op <= 11) begin
            s = 1;
            d = 0;
        end
        if (op == 13 || op == 15)
            n = 0;
        case (f.kind)
            3'd0: op2 = int'(f.sh_amt) * 128 + int'(f.sh_type) * 32
                        + int'(f.rm);
            3'd1: op2 = int'(f.rs) * 256 + int'(f.sh_type) * 32 + 16
                        + int'(f.rm);
            3'd2: begin
                r = find_rot(f.imm32, i8);
                ibit = 1;
                if (r < 0) begin
                    e = 1;
                    lat = 17;
                end else begin
                    op2 = r * 256 + i8;
                    lat = r + 2;
                end
            end
            default: ;
        endcase
        if (f.kind <= 3'd2 && !e)
            w = (32'(c) << 28) | (32'(ibit) << 25) | (32'(op) << 21)
              | (32'(s) << 20) | (32'(n) << 16) | (32'(d) << 12)
              | 32'(op2);
        else if (f.kind == 3'd3 || f.kind == 3'd4)
            w = (32'(c) << 28) | (32'(f.kind == 3'd4) << 21)
              | (32'(f.s_bit) << 20) | (32'(f.rd) << 16)
              | ((f.kind == 3'd4) ? (32'(f.rn) << 12) : 32'd0)
              | (32'(f.rs) << 8) | (32'd9 << 4) | 32'(f.rm);
        else if (f.kind == 3'd5 || f.kind == 3'd6)
            w = (32'(c) << 28) | (32'd1 << 23) | (32'(f.kind == 3'd6) << 22)
              | (32'(f.s_bit) << 20) | (32'(f.rd) << 16)
              | (32'(f.rn) << 12) | (32'(f.rs) << 8) | (32'd9 << 4)
              | 32'(f.rm);
        else if (f.kind == 3'd7)
            e = 1;
    endtask

    task automatic apply(input fld_t f);
        kind = f.kind;
        cond = f.cond;
        opcode = f.opcode;
        s_bit = f.s_bit;
        rn = f.rn;
        rd = f.rd;
        rm = f.rm;
        rs = f.rs;
        sh_type = f.sh_type;
        sh_amt = f.sh_amt;
        imm32 = f.imm32;
    endtask

    task automatic run_op(input fld_t f, output logic [31:0] w,
                          output logic e, output int lat);
        @(negedge clk);
        apply(f);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        w = instr;
        e = err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        if (instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_instr: got %h want 0", instr);
        end
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", err);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        fld_t        v [10];
        logic [31:0] xw [10];
        logic        xe [10];
        int          xl [10];
        logic [31:0] w;
        logic        e;
        int          lat;
        v[0] = mk(0, 14, 4, 0, 2, 1, 3, 0, 0, 0, 0);
        xw[0] = 32'hE0821003; xe[0] = 0; xl[0] = 1;
        v[1] = mk(1, 14, 4, 0, 1, 0, 2, 3, 0, 0, 0);
        xw[1] = 32'hE0810312; xe[1] = 0; xl[1] = 1;
        v[2] = mk(2, 14, 13, 0, 7, 0, 0, 0, 0, 0, 32'hFF000000);
        xw[2] = 32'hE3A004FF; xe[2] = 0; xl[2] = 6;
        v[3] = mk(2, 14, 13, 0, 0, 0, 0, 0, 0, 0, 32'h00000101);
        xw[3] = 32'h0; xe[3] = 1; xl[3] = 17;
        v[4] = mk(0, 14, 10, 0, 1, 5, 2, 0, 0, 0, 0);
        xw[4] = 32'hE1510002; xe[4] = 0; xl[4] = 1;
        v[5] = mk(3, 14, 0, 0, 4, 0, 1, 2, 0, 0, 0);
        xw[5] = 32'hE0000291; xe[5] = 0; xl[5] = 1;
        v[6] = mk(5, 14, 0, 0, 0, 1, 2, 3, 0, 0, 0);
        xw[6] = 32'hE0810392; xe[6] = 0; xl[6] = 1;
        v[7] = mk(7, 14, 4, 0, 1, 1, 1, 1, 0, 0, 0);
        xw[7] = 32'h0; xe[7] = 1; xl[7] = 1;
        v[8] = mk(2, 14, 4, 1, 1, 2, 0, 0, 0, 0, 32'h000000AB);
        xw[8] = 32'hE29120AB; xe[8] = 0; xl[8] = 2;
        v[9] = mk(2, 14, 13, 0, 0, 3, 0, 0, 0, 0, 32'h00000304);
        xw[9] = 32'hE3A03FC1; xe[9] = 0; xl[9] = 17;
        for (int i = 0; i < 10; i++) begin
            run_op(v[i], w, e, lat);
            checks += 3;
            if (w !== xw[i]) begin
                errors++;
                $display("FAIL dir%0d_instr: got %h want %h", i, w, xw[i]);
            end
            if (e !== xe[i]) begin
                errors++;
                $display("FAIL dir%0d_err: got %b want %b", i, e, xe[i]);
            end
            if (lat != xl[i]) begin
                errors++;
                $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, xl[i]);
            end
        end
    endtask

    task automatic test_abort();
        int          seen;
        logic [31:0] w;
        logic        e;
        int          lat;
        @(negedge clk);
        apply(mk(2, 14, 13, 0, 0, 0, 0, 0, 0, 0, 32'h00000101));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 3;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_ready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_out_valid: got %b want 0", out_valid);
        end
        if (instr !== 32'd0) begin
            errors++;
            $display("FAIL abort_instr: got %h want 0", instr);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1)
                seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d valid cycles want 0", seen);
        end
        @(negedge clk);
        apply(mk(2, 14, 13, 0, 0, 0, 0, 0, 0, 0, 32'hFF000000));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL outrst_valid: got %b want 0", out_valid);
        end
        if (instr !== 32'd0) begin
            errors++;
            $display("FAIL outrst_instr: got %h want 0", instr);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL outrst_in_ready: got %b want 1", in_ready);
        end
        run_op(mk(0, 14, 4, 0, 2, 1, 3, 0, 0, 0, 0), w, e, lat);
        checks++;
        if (w !== 32'hE0821003) begin
            errors++;
            $display("FAIL abort_resume: got %h want E0821003", w);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] xw;
        logic        xe;
        int          xl;
        fld_t        nf;
        @(negedge clk);
        apply(mk(0, 14, 4, 0, 2, 1, 3, 0, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        nf = mk(0, 14, 4, 0, 2, 1, 9, 0, 0, 0, 0);
        apply(nf);
        for (int i = 0; i < 10; i++) begin
            checks += 3;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp%0d_valid: got %b want 1", i, out_valid);
            end
            if (instr !== 32'hE0821003) begin
                errors++;
                $display("FAIL bp%0d_instr: got %h want E0821003", i, instr);
            end
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_valid: got %b want 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ref_encode(nf, xw, xe, xl);
        checks += 2;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_valid: got %b want 1", out_valid);
        end
        if (instr !== xw) begin
            errors++;
            $display("FAIL bp_next_instr: got %h want %h", instr, xw);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        fld_t        f;
        logic [31:0] w, xw;
        logic        e, xe;
        int          lat, xl;
        for (int i = 0; i < 60; i++) begin
            f = mk($urandom_range(0, 7), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 1),
                   $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 3), $urandom_range(0, 31), 32'd0);
            if ($urandom_range(0, 2) != 0)
                f.imm32 = ror32(32'($urandom_range(0, 255)),
                                2 * $urandom_range(0, 15));
            else
                f.imm32 = $urandom;
            if (i % 4 == 0)
                f.kind = 3'd2;
            ref_encode(f, xw, xe, xl);
            run_op(f, w, e, lat);
            checks += 3;
            if (w !== xw) begin
                errors++;
                $display("FAIL rnd%0d_instr: kind %0d got %h want %h",
                         i, f.kind, w, xw);
            end
            if (e !== xe) begin
                errors++;
                $display("FAIL rnd%0d_err: got %b want %b", i, e, xe);
            end
            if (lat != xl) begin
                errors++;
                $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, xl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields and produces the 32-bit ARM instruction word.
- Covers data-processing forms (register with immediate shift, register with register shift, rotated immediate) and MUL/MLA/UMULL/SMULL.
- For immediate operands it searches for a legal imm8/rotate pair, one candidate per cycle.
- Sits between the testbench/assembler front-end and instruction memory; words are fed back through the decoder for round-trip checks.

Parameters:
- MAX_ROT, 15, highest rotate candidate tried (must be 15 for full ARM coverage; lower values only for reduced test builds).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- kind  in  3  ENC_DP_RSI=0, ENC_DP_RSR=1, ENC_DP_IMM=2, ENC_MUL=3, ENC_MLA=4, ENC_UMULL=5, ENC_SMULL=6; codes 7 and above are illegal.
- cond  in  4  condition field.
- opcode  in  4  data-processing opcode, ignored for multiplies.
- s_bit  in  1  set-flags request.
- rn, rd, rm, rs  in  4 each  register numbers; for long multiplies rd = RdHi and rn = RdLo.
- sh_type  in  2  LSL=0, LSR=1, ASR=2, ROR=3.
- sh_amt  in  5  immediate shift amount.
- imm32  in  32  constant for ENC_DP_IMM.
- out_valid  out  1  instr/err valid.
- out_ready  in  1  consumer accepts.
- instr  out  32  encoded word.
- err  out  1  encoding failed; instr is then 0.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; instr=0; err=0; internal rotate counter=0.
- Reset asserted in any state, including mid-SEARCH or while holding output, aborts the operation and returns to the reset values next cycle. The pending bundle is dropped.
- States:
  - IDLE: in_ready=1. On in_valid, capture all inputs.
    - kind=ENC_DP_IMM: go to SEARCH with r=0.
    - kind illegal (>=7): go to OUT with err=1, instr=0.
    - Any other kind: build the word combinationally from captured fields; go to OUT.
  - SEARCH: in_ready=0. Compute v = imm32 rotated left by 2*r.
    - If v[31:24]... more precisely v[31:8]==0: op2={r[3:0], v[7:0]}; go to OUT.
    - Else if r==MAX_ROT: err=1, instr=0; go to OUT.
    - Else r=r+1.
    - The smallest legal r always wins (deterministic encoding).
  - OUT: out_valid=1; instr/err stable. On out_ready: go to IDLE, out_valid=0 next cycle. Held indefinitely under backpressure.
- Latency, counted from the accepting edge to the first cycle with out_valid=1:
  - Non-immediate kinds: 1 cycle.
  - Immediate found at candidate r: r+2 cycles.
  - Unencodable immediate: MAX_ROT+2 cycles.
- No new accept while in OUT, so throughput is at most one word per 2 cycles.
- Data-processing encoding: [31:28]=cond, [27:26]=00, [25]=I, [24:21]=opcode, [20]=S, [19:16]=Rn, [15:12]=Rd, [11:0]=op2.
  - I=1 only for ENC_DP_IMM.
  - RSI op2 = {sh_amt, sh_type, 1'b0, rm}.
  - RSR op2 = {rs, 1'b0, sh_type, 1'b1, rm}.
- Field normalisation:
  - TST/TEQ/CMP/CMN (opcode 10xx): S forced to 1 and Rd forced to 0.
  - MOV/MVN (opcode 1101, 1111): Rn forced to 0.
- MUL/MLA word: {cond, 6'b000000, A, S, rd, rn, rs, 4'b1001, rm}, with A=1 for MLA. For MUL, rn is forced to 0.
- UMULL/SMULL word: {cond, 5'b00001, U, 1'b0, S, rd(Hi), rn(Lo), rs, 4'b1001, rm}, with U=1 for SMULL.

Decomposition:
- Shared package arm_enc_pkg holds:
  - the kind codes;
  - the sh_type codes;
  - the opcode constants, shared with the decoder;
  - the state encoding (IDLE, SEARCH, OUT);
  - the 4'b1001 multiply marker.
- One sub-module, arm_imm_rot_check: combinational; takes imm32 and r, returns fit and imm8. It is reusable by the decoder bench to check operand-2 immediates.

Test Plan:
- ENC_DP_RSI ADD, cond=E, rn=2, rd=1, rm=3, sh_amt=0 -> instr=E0821003, err=0, out_valid 1 cycle after accept.
- ENC_DP_RSR ADD, rn=1, rd=0, rm=2, rs=3, LSL -> E0810312.
- ENC_DP_IMM MOV, rd=0, imm32=FF000000, rn input=7 -> rn forced to 0; r=4; instr=E3A004FF; out_valid 6 cycles after accept.
- ENC_DP_IMM, imm32=00000101 -> err=1, instr=0 after 17 cycles. Repeat with rst pulsed at search cycle 5 -> IDLE, out_valid stays 0.
- CMP, rn=1, rm=2, s_bit=0 -> E1510002. MUL, rd=0, rm=1, rs=2 -> E0000291. UMULL, rd=1, rn=0, rs=3, rm=2 -> E0810392.
- Backpressure: out_ready=0 for 10 cycles -> instr/out_valid stable, in_ready=0, in_valid ignored. Release -> accept resumes in IDLE the following cycle.
